// File: rtl/image_tx_pkg.sv
// Shared definitions for the frame-dump UART path: state encoding, header bytes,
// RGB444 field positions and the pixel-to-byte split.
package image_tx_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_HDR0    = 3'd1;
    localparam state_t ST_HDR1    = 3'd2;
    localparam state_t ST_READ    = 3'd3;
    localparam state_t ST_WAIT    = 3'd4;
    localparam state_t ST_SEND_HI = 3'd5;
    localparam state_t ST_SEND_LO = 3'd6;
    localparam state_t ST_DONE    = 3'd7;

    localparam logic [7:0] HDR_BYTE0 = 8'hA5;
    localparam logic [7:0] HDR_BYTE1 = 8'h5A;

    localparam int R_MSB = 11;
    localparam int R_LSB = 8;
    localparam int G_MSB = 7;
    localparam int G_LSB = 4;
    localparam int B_MSB = 3;
    localparam int B_LSB = 0;

    // Cycles before the end of a stop bit at which the serializer reports the byte
    // as finished; covers the READ/WAIT/SEND_HI hop so the next start bit is not delayed.
    localparam int READY_LEAD = 4;

    function automatic logic [7:0] pix_hi(input logic [11:0] pix);
        return {4'h0, pix[R_MSB:R_LSB]};
    endfunction

    function automatic logic [7:0] pix_lo(input logic [11:0] pix);
        return {pix[G_MSB:G_LSB], pix[B_MSB:B_LSB]};
    endfunction

endpackage

// File: rtl/image_tx_uart_tx.sv
// 8N1 serializer with a one-byte pending slot that opens only in the stop-bit tail,
// so back-to-back bytes leave no idle gap on the line.
module uart_tx
    import image_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       i_clk_sys,
    input  logic       i_rst_n,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    output logic       o_ready,
    output logic       o_tx
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] BIT_END    = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] TAIL_START = CW'(CLKS_PER_BIT - READY_LEAD);
    localparam logic [3:0]    STOP_BIT   = 4'd9;

    logic          active;
    logic          pend_valid;
    logic [7:0]    pend_data;
    logic [9:0]    shift_q;
    logic [CW-1:0] baud_cnt;
    logic [3:0]    bit_cnt;
    logic          bit_end;
    logic          in_stop;
    logic          accept;
    logic [7:0]    next_data;

    assign bit_end   = (baud_cnt == BIT_END);
    assign in_stop   = active && (bit_cnt == STOP_BIT);
    assign o_ready   = !active || (in_stop && (baud_cnt >= TAIL_START) && !pend_valid);
    assign accept    = i_valid && o_ready;
    assign next_data = pend_valid ? pend_data : i_data;
    // Line is driven straight from a flop; idle shifter content is all ones.
    assign o_tx      = shift_q[0];

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            active     <= 1'b0;
            pend_valid <= 1'b0;
            pend_data  <= '0;
            shift_q    <= '1;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
        end else if (!active) begin
            if (accept) begin
                shift_q  <= {1'b1, i_data, 1'b0};
                active   <= 1'b1;
                baud_cnt <= '0;
                bit_cnt  <= '0;
            end
        end else begin
            if (accept) begin
                pend_valid <= 1'b1;
                pend_data  <= i_data;
            end
            if (bit_end) begin
                baud_cnt <= '0;
                if (in_stop) begin
                    bit_cnt    <= '0;
                    pend_valid <= 1'b0;
                    if (pend_valid || accept) begin
                        shift_q <= {1'b1, next_data, 1'b0};
                    end else begin
                        active <= 1'b0;
                    end
                end else begin
                    bit_cnt <= bit_cnt + 4'd1;
                    shift_q <= {1'b1, shift_q[9:1]};
                end
            end else begin
                baud_cnt <= baud_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/image_tx.sv
// Frame dump controller: reads RGB444 pixels from SPRAM and streams a header plus
// two bytes per pixel through the UART serializer.
module image_tx
    import image_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115200,
    parameter int PIX_NUM  = 19200
) (
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic        i_start,
    input  logic        i_abort,
    output logic        o_rd_en,
    output logic [14:0] o_rd_addr,
    input  logic [11:0] i_rd_data,
    output logic        o_uart_tx,
    output logic        o_busy,
    output logic        o_done,
    output logic [14:0] o_pix_cnt
);

    localparam int          CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam logic [14:0] LAST_ADDR    = 15'(PIX_NUM - 1);
    localparam logic [14:0] PIX_MAX      = 15'(PIX_NUM);

    state_t      state;
    state_t      state_nx;
    state_t      follow;
    logic        issued;
    logic        abort_req;
    logic        stop_req;
    logic        send_st;
    logic        byte_done;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic [11:0] pix_q;

    assign send_st   = (state == ST_HDR0) || (state == ST_HDR1) ||
                       (state == ST_SEND_HI) || (state == ST_SEND_LO);
    assign stop_req  = abort_req || i_abort;
    assign tx_valid  = send_st && !issued && !stop_req;
    assign byte_done = send_st && issued && tx_ready;

    assign o_rd_en = (state == ST_READ);
    assign o_busy  = (state != ST_IDLE);
    assign o_done  = (state == ST_DONE);

    always_comb begin
        tx_data = '0;
        case (state)
            ST_HDR0:    tx_data = HDR_BYTE0;
            ST_HDR1:    tx_data = HDR_BYTE1;
            ST_SEND_HI: tx_data = pix_hi(pix_q);
            ST_SEND_LO: tx_data = pix_lo(pix_q);
            default:    tx_data = '0;
        endcase
    end

    always_comb begin
        follow = ST_IDLE;
        case (state)
            ST_HDR0:    follow = ST_HDR1;
            ST_HDR1:    follow = ST_READ;
            ST_SEND_HI: follow = ST_SEND_LO;
            ST_SEND_LO: follow = (o_rd_addr == LAST_ADDR) ? ST_DONE : ST_READ;
            default:    follow = ST_IDLE;
        endcase
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (i_start && !i_abort) state_nx = ST_HDR0;
            end
            ST_HDR0, ST_HDR1, ST_SEND_HI, ST_SEND_LO: begin
                // An abort before the byte is handed over means nothing is in flight.
                if (!issued && stop_req) begin
                    state_nx = ST_IDLE;
                end else if (byte_done) begin
                    state_nx = stop_req ? ST_IDLE : follow;
                end
            end
            ST_READ: state_nx = stop_req ? ST_IDLE : ST_WAIT;
            ST_WAIT: state_nx = stop_req ? ST_IDLE : ST_SEND_HI;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= ST_IDLE;
            issued    <= 1'b0;
            abort_req <= 1'b0;
            pix_q     <= '0;
            o_rd_addr <= '0;
            o_pix_cnt <= '0;
        end else begin
            state <= state_nx;

            if (state_nx != state) begin
                issued <= 1'b0;
            end else if (tx_valid && tx_ready) begin
                issued <= 1'b1;
            end

            if (state == ST_IDLE) begin
                abort_req <= 1'b0;
            end else if (i_abort) begin
                abort_req <= 1'b1;
            end

            if ((state == ST_IDLE) && (state_nx == ST_HDR0)) begin
                o_rd_addr <= '0;
                o_pix_cnt <= '0;
            end

            if (state == ST_WAIT) begin
                pix_q <= i_rd_data;
            end

            if ((state == ST_SEND_LO) && byte_done) begin
                if (o_rd_addr != LAST_ADDR) o_rd_addr <= o_rd_addr + 15'd1;
                if (o_pix_cnt != PIX_MAX)   o_pix_cnt <= o_pix_cnt + 15'd1;
            end
        end
    end

    uart_tx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_tx (
        .i_clk_sys(i_clk_sys),
        .i_rst_n  (i_rst_n),
        .i_valid  (tx_valid),
        .i_data   (tx_data),
        .o_ready  (tx_ready),
        .o_tx     (o_uart_tx)
    );

endmodule

// File: tb/tb_image_tx.sv
// Directed bench for image_tx: a 4-pixel frame decoded from the serial line,
// checked for content, bit timing, abort, start filtering and reset recovery.
module tb_image_tx;

    localparam int CLK_FREQ  = 1_843_200;
    localparam int BAUD      = 115_200;
    localparam int PIX_NUM   = 4;
    localparam int CLKS      = CLK_FREQ / BAUD;
    localparam int BYTE_CLKS = 10 * CLKS;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [11:0] rd_data = '0;
    logic        tx;
    logic        busy;
    logic        done;
    logic [14:0] pix_cnt;

    logic [11:0] mem [4] = '{12'hF0A, 12'h123, 12'h000, 12'hFFF};
    logic [7:0]  exp_frame [10] = '{8'hA5, 8'h5A, 8'h0F, 8'h0A, 8'h01,
                                    8'h23, 8'h00, 8'h00, 8'h0F, 8'hFF};

    int checks = 0;
    int fails  = 0;

    int          cyc = 0;
    bit          mon_busy = 1'b0;
    int          mon_cnt = 0;
    int          mon_bit = 0;
    logic        mon_val = 1'b1;
    logic [7:0]  mon_byte = '0;
    int          mon_glitch = 0;
    int          mon_ferr = 0;
    int          done_cnt = 0;
    int          rd_idle_err = 0;
    logic [7:0]  rx_q [$];
    int          rx_t [$];
    logic [14:0] rd_q [$];

    image_tx #(
        .CLK_FREQ(CLK_FREQ),
        .BAUD    (BAUD),
        .PIX_NUM (PIX_NUM)
    ) dut (
        .i_clk_sys(clk),
        .i_rst_n  (rst_n),
        .i_start  (start),
        .i_abort  (abort),
        .o_rd_en  (rd_en),
        .o_rd_addr(rd_addr),
        .i_rd_data(rd_data),
        .o_uart_tx(tx),
        .o_busy   (busy),
        .o_done   (done),
        .o_pix_cnt(pix_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // SPRAM model: data valid the cycle after the strobe, junk otherwise.
    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr[1:0]] : 12'($urandom);

    // Line decoder: every cycle of each bit window must hold the window's first value.
    always @(negedge clk) begin
        if (!rst_n) begin
            mon_busy = 1'b0;
        end else begin
            if (done === 1'b1) done_cnt++;
            if (rd_en === 1'b1) begin
                rd_q.push_back(rd_addr);
                if (busy !== 1'b1) rd_idle_err++;
            end
            if (mon_busy) begin
                if (mon_cnt == CLKS) begin
                    mon_cnt = 0;
                    mon_bit++;
                    if (mon_bit == 10) begin
                        rx_q.push_back(mon_byte);
                        mon_busy = 1'b0;
                    end else begin
                        mon_val = tx;
                    end
                end
                if (mon_busy) begin
                    if (tx !== mon_val) mon_glitch++;
                    if (mon_cnt == 0 && mon_bit >= 1 && mon_bit <= 8) mon_byte[mon_bit-1] = tx;
                    if (mon_cnt == 0 && mon_bit == 9 && tx !== 1'b1) mon_ferr++;
                    mon_cnt++;
                end
            end
            if (!mon_busy && tx === 1'b0) begin
                mon_busy = 1'b1;
                mon_bit  = 0;
                mon_cnt  = 1;
                mon_val  = 1'b0;
                rx_t.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input int d0, output bit ok);
        int budget;
        budget = 20 * BYTE_CLKS;
        while (done_cnt == d0 && budget > 0) begin
            tick(1);
            budget--;
        end
        ok = (done_cnt != d0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(3);
        checks++; if (tx !== 1'b1)     begin fails++; $display("FAIL reset_tx: got %b expected 1", tx); end
        checks++; if (rd_en !== 1'b0)  begin fails++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr !== '0)  begin fails++; $display("FAIL reset_addr: got %0d expected 0", rd_addr); end
        checks++; if (busy !== 1'b0)   begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0)   begin fails++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (pix_cnt !== '0)  begin fails++; $display("FAIL reset_pix_cnt: got %0d expected 0", pix_cnt); end
        rst_n = 1'b1;
        tick(2);
    endtask

    task automatic test_idle();
        int lows;
        int rds;
        lows = 0;
        rds  = 0;
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
            if (rd_en !== 1'b0) rds++;
        end
        tick(1);
        checks++; if (lows != 0) begin fails++; $display("FAIL idle_tx: got %0d low cycles expected 0", lows); end
        checks++; if (rds != 0)  begin fails++; $display("FAIL idle_rd_en: got %0d strobes expected 0", rds); end
    endtask

    task automatic check_frame(input string tag, input int b0, input int t0);
        checks++;
        if (rx_q.size() != b0 + 10) begin
            fails++;
            $display("FAIL %s_len: got %0d bytes expected 10", tag, rx_q.size() - b0);
        end else begin
            for (int i = 0; i < 10; i++) begin
                checks++;
                if (rx_q[b0+i] !== exp_frame[i]) begin
                    fails++;
                    $display("FAIL %s_byte%0d: got %02h expected %02h", tag, i, rx_q[b0+i], exp_frame[i]);
                end
            end
            for (int i = 1; i < 10; i++) begin
                checks++;
                if (rx_t[t0+i] - rx_t[t0+i-1] != BYTE_CLKS) begin
                    fails++;
                    $display("FAIL %s_spacing%0d: got %0d cycles expected %0d", tag, i,
                             rx_t[t0+i] - rx_t[t0+i-1], BYTE_CLKS);
                end
            end
        end
    endtask

    task automatic test_frame();
        int b0, t0, d0, r0, g0, f0;
        bit ok;
        b0 = rx_q.size(); t0 = rx_t.size(); d0 = done_cnt; r0 = rd_q.size();
        g0 = mon_glitch; f0 = mon_ferr;
        pulse_start();
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL frame_busy_rise: got %b expected 1", busy); end
        wait_done(d0, ok);
        checks++; if (!ok) begin fails++; $display("FAIL frame_done_timeout: got no done expected 1 pulse"); end
        tick(2 * CLKS);
        check_frame("frame", b0, t0);
        checks++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL frame_done_cnt: got %0d expected 1", done_cnt - d0); end
        checks++; if (pix_cnt !== 15'd4) begin fails++; $display("FAIL frame_pix_cnt: got %0d expected 4", pix_cnt); end
        checks++; if (rd_addr !== 15'd3) begin fails++; $display("FAIL frame_addr: got %0d expected 3", rd_addr); end
        checks++; if (busy !== 1'b0)     begin fails++; $display("FAIL frame_busy_fall: got %b expected 0", busy); end
        checks++; if (mon_glitch != g0)  begin fails++; $display("FAIL frame_bit_time: got %0d unstable samples expected 0", mon_glitch - g0); end
        checks++; if (mon_ferr != f0)    begin fails++; $display("FAIL frame_stop_bit: got %0d errors expected 0", mon_ferr - f0); end
        checks++;
        if (rd_q.size() != r0 + 4) begin
            fails++;
            $display("FAIL frame_rd_count: got %0d expected 4", rd_q.size() - r0);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rd_q[r0+i] !== 15'(i)) begin
                    fails++;
                    $display("FAIL frame_rd_addr%0d: got %0d expected %0d", i, rd_q[r0+i], i);
                end
            end
        end
    endtask

    task automatic test_abort();
        int b0, t0, d0, budget;
        b0 = rx_q.size(); t0 = rx_t.size(); d0 = done_cnt;
        pulse_start();
        budget = 10 * BYTE_CLKS;
        while (rx_t.size() < t0 + 5 && budget > 0) begin tick(1); budget--; end
        checks++; if (budget == 0) begin fails++; $display("FAIL abort_reach_pix1: got %0d starts expected 5", rx_t.size() - t0); end
        tick(4 * CLKS);
        abort = 1'b1;
        budget = 2 * BYTE_CLKS;
        while (busy === 1'b1 && budget > 0) begin tick(1); budget--; end
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy_fall: got %b expected 0", busy); end
        tick(3 * BYTE_CLKS);
        checks++;
        if (rx_q.size() != b0 + 5) begin
            fails++;
            $display("FAIL abort_len: got %0d bytes expected 5", rx_q.size() - b0);
        end else begin
            checks++; if (rx_q[b0+3] !== 8'h0A) begin fails++; $display("FAIL abort_pix0_lo: got %02h expected 0a", rx_q[b0+3]); end
            checks++; if (rx_q[b0+4] !== 8'h01) begin fails++; $display("FAIL abort_pix1_hi: got %02h expected 01", rx_q[b0+4]); end
        end
        checks++; if (done_cnt != d0)    begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
        checks++; if (pix_cnt !== 15'd1) begin fails++; $display("FAIL abort_pix_cnt: got %0d expected 1", pix_cnt); end
        checks++; if (rd_addr !== 15'd1) begin fails++; $display("FAIL abort_addr: got %0d expected 1", rd_addr); end
    endtask

    task automatic test_start_abort_idle();
        int b0, r0;
        b0 = rx_t.size(); r0 = rd_q.size();
        start = 1'b1;
        abort = 1'b1;
        tick(1);
        start = 1'b0;
        abort = 1'b0;
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL start_abort_busy: got %b expected 0", busy); end
        tick(2 * BYTE_CLKS);
        checks++; if (rx_t.size() != b0) begin fails++; $display("FAIL start_abort_line: got %0d bytes expected 0", rx_t.size() - b0); end
        checks++; if (rd_q.size() != r0) begin fails++; $display("FAIL start_abort_rd: got %0d reads expected 0", rd_q.size() - r0); end
    endtask

    task automatic test_back_to_back();
        int b0, t0, d0, r0;
        bit ok;
        b0 = rx_q.size(); t0 = rx_t.size(); d0 = done_cnt;
        pulse_start();
        tick(3 * CLKS);
        pulse_start();
        tick(3 * BYTE_CLKS);
        pulse_start();
        wait_done(d0, ok);
        checks++; if (!ok) begin fails++; $display("FAIL b2b_done_timeout: got no done expected 1 pulse"); end
        tick(3 * BYTE_CLKS);
        checks++; if (rx_q.size() != b0 + 10) begin fails++; $display("FAIL b2b_one_frame: got %0d bytes expected 10", rx_q.size() - b0); end
        checks++; if (done_cnt - d0 != 1)     begin fails++; $display("FAIL b2b_done_cnt: got %0d expected 1", done_cnt - d0); end
        checks++; if (busy !== 1'b0)          begin fails++; $display("FAIL b2b_no_queue: got busy %b expected 0", busy); end
        b0 = rx_q.size(); t0 = rx_t.size(); d0 = done_cnt; r0 = rd_q.size();
        pulse_start();
        wait_done(d0, ok);
        checks++; if (!ok) begin fails++; $display("FAIL fresh_done_timeout: got no done expected 1 pulse"); end
        tick(2 * CLKS);
        checks++;
        if (rd_q.size() <= r0) begin
            fails++;
            $display("FAIL fresh_first_addr: got no read expected address 0");
        end else if (rd_q[r0] !== 15'd0) begin
            fails++;
            $display("FAIL fresh_first_addr: got %0d expected 0", rd_q[r0]);
        end
        check_frame("fresh", b0, t0);
    endtask

    task automatic test_reset_mid_stop();
        int t0, b0, d0, budget, lows;
        bit ok;
        t0 = rx_t.size();
        pulse_start();
        budget = 2 * BYTE_CLKS;
        while (rx_t.size() == t0 && budget > 0) begin tick(1); budget--; end
        checks++; if (budget == 0) begin fails++; $display("FAIL rst_mid_first_byte: got no start bit expected 1"); end
        tick(9 * CLKS - 1 + CLKS / 2);
        rst_n = 1'b0;
        #1;
        checks++; if (tx !== 1'b1)    begin fails++; $display("FAIL rst_mid_tx: got %b expected 1", tx); end
        checks++; if (busy !== 1'b0)  begin fails++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
        checks++; if (pix_cnt !== '0) begin fails++; $display("FAIL rst_mid_pix_cnt: got %0d expected 0", pix_cnt); end
        tick(3);
        rst_n = 1'b1;
        lows = 0;
        for (int i = 0; i < 3 * CLKS; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        tick(1);
        checks++; if (lows != 0) begin fails++; $display("FAIL rst_mid_release_glitch: got %0d low cycles expected 0", lows); end
        b0 = rx_q.size(); t0 = rx_t.size(); d0 = done_cnt;
        pulse_start();
        wait_done(d0, ok);
        checks++; if (!ok) begin fails++; $display("FAIL rst_mid_done_timeout: got no done expected 1 pulse"); end
        tick(2 * CLKS);
        check_frame("restart", b0, t0);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_frame();
        test_abort();
        test_start_abort_idle();
        test_back_to_back();
        test_reset_mid_stop();
        checks++;
        if (rd_idle_err != 0) begin
            fails++;
            $display("FAIL rd_en_while_idle: got %0d strobes expected 0", rd_idle_err);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
